// File: rtl/frame_pkg.sv
// Shared constants, FSM state type and round-robin grant helper for the
// frame stream arbiter.
package frame_pkg;

    localparam int FRAME_DATA_WIDTH = 64;
    localparam int FRAME_LEN_LSB    = 0;
    localparam int FRAME_LEN_WIDTH  = 8;
    localparam int FRAME_MAX_LENGTH = 200;
    localparam int RR_MAX_CH        = 16;

    typedef enum logic [1:0] {IDLE, HDR, BODY, FTR} arb_state_e;

    // One-hot grant of the first requester after 'last', wrapping within n_ch.
    function automatic logic [RR_MAX_CH-1:0] rr_next(
        input logic [RR_MAX_CH-1:0] request,
        input logic [3:0]           last,
        input int                   n_ch
    );
        logic [RR_MAX_CH-1:0] grant;
        logic [3:0]           idx;
        grant = '0;
        for (int i = 1; i <= RR_MAX_CH; i++) begin
            idx = 4'((int'(last) + i) % n_ch);
            if (i <= n_ch && grant == '0 && request[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer with a registered output; in_ready depends only on
// local occupancy, so no combinational path runs from out_ready to in_ready.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? entry1_q : entry0_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The head entry is never overwritten while occupied, so out_data holds during a stall.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            if (wr_ptr_q) begin
                entry1_d = in_data;
            end else begin
                entry0_d = in_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-atomic round-robin merge of N_CH frame streams into one tagged output
// stream; frame length comes from the data-word count in each header word.
module frame_stream_arbiter
    import frame_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int DATA_WIDTH       = FRAME_DATA_WIDTH,
    parameter int LEN_LSB          = FRAME_LEN_LSB,
    parameter int MAX_FRAME_LENGTH = FRAME_MAX_LENGTH,
    parameter int CH_ID_WIDTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic [N_CH-1:0]            CH_ENABLE,
    input  logic [N_CH-1:0]            iVALID,
    input  logic [N_CH*DATA_WIDTH-1:0] DIN,
    output logic [N_CH-1:0]            oREADY,
    input  logic                       iREADY,
    output logic                       oVALID,
    output logic [DATA_WIDTH-1:0]      DOUT,
    output logic                       oLAST,
    output logic [CH_ID_WIDTH-1:0]     oCH_ID,
    output logic                       BUSY,
    output logic                       LEN_ERR
);

    localparam int SKID_W = DATA_WIDTH + 1 + CH_ID_WIDTH;
    localparam logic [FRAME_LEN_WIDTH-1:0] LEN_ONE = 1;

    arb_state_e                 state_q, state_d;
    logic [3:0]                 grant_q, grant_d;
    logic [3:0]                 last_grant_q, last_grant_d;
    logic [FRAME_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                       len_err_q, len_err_d;
    logic [FRAME_LEN_WIDTH-1:0] hdr_len;
    logic [RR_MAX_CH-1:0]       rr_grant;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic                       skid_ready;
    logic                       xfer;
    logic [SKID_W-1:0]          skid_in;
    logic [SKID_W-1:0]          skid_out;

    always_comb begin
        sel_data = '0;
        oREADY   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_q == 4'(c)) begin
                sel_data = DIN[c*DATA_WIDTH +: DATA_WIDTH];
            end
            oREADY[c] = (state_q != IDLE) && skid_ready && (grant_q == 4'(c));
        end
    end

    assign xfer     = |(iVALID & oREADY);
    assign hdr_len  = sel_data[LEN_LSB +: FRAME_LEN_WIDTH];
    assign rr_grant = rr_next(RR_MAX_CH'(iVALID & CH_ENABLE), last_grant_q, N_CH);
    assign skid_in  = {sel_data, (state_q == FTR), CH_ID_WIDTH'(grant_q)};

    // Over-long counts are still honoured; they only raise the sticky flag.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        len_err_d    = len_err_q;
        case (state_q)
            IDLE: begin
                if (rr_grant != '0) begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (rr_grant[c]) grant_d = 4'(c);
                    end
                    state_d = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    cnt_d = hdr_len;
                    if (int'(hdr_len) > MAX_FRAME_LENGTH) len_err_d = 1'b1;
                    state_d = (hdr_len != '0) ? BODY : FTR;
                end
            end
            BODY: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) state_d = FTR;
                end
            end
            FTR: begin
                if (xfer) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            grant_q      <= 4'd0;
            last_grant_q <= 4'(N_CH - 1);
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    stream_skid_buffer #(
        .WIDTH (SKID_W)
    ) u_out_skid (
        .clk       (CLK),
        .rst_n     (RESETN),
        .in_valid  (xfer),
        .in_ready  (skid_ready),
        .in_data   (skid_in),
        .out_valid (oVALID),
        .out_ready (iREADY),
        .out_data  (skid_out)
    );

    assign {DOUT, oLAST, oCH_ID} = skid_out;
    assign BUSY    = (state_q != IDLE);
    assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Bench for frame_stream_arbiter: per-channel frame sources, a stalling sink
// and an expected-word queue checked against every output beat.
module tb_frame_stream_arbiter;

    localparam int N_CH = 4;
    localparam int DW   = 64;
    localparam int CHW  = 4;
    localparam int EW   = DW + 1 + CHW;

    logic             CLK = 1'b0;
    logic             RESETN = 1'b0;
    logic [N_CH-1:0]  CH_ENABLE = '1;
    logic [N_CH-1:0]  iVALID = '0;
    logic [N_CH*DW-1:0] DIN = '0;
    logic [N_CH-1:0]  oREADY;
    logic             iREADY = 1'b1;
    logic             oVALID;
    logic [DW-1:0]    DOUT;
    logic             oLAST;
    logic [CHW-1:0]   oCH_ID;
    logic             BUSY;
    logic             LEN_ERR;

    int n_cmp = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] src_q[N_CH][$];
    int acc_cnt = 0;
    int del_cnt = 0;
    bit saw_full = 1'b0;
    bit stall_mode = 1'b0;
    int stall_phase = 0;
    int frame_no = 0;

    frame_stream_arbiter #(
        .N_CH             (N_CH),
        .DATA_WIDTH       (DW),
        .LEN_LSB          (0),
        .MAX_FRAME_LENGTH (200),
        .CH_ID_WIDTH      (CHW)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .CH_ENABLE (CH_ENABLE),
        .iVALID    (iVALID),
        .DIN       (DIN),
        .oREADY    (oREADY),
        .iREADY    (iREADY),
        .oVALID    (oVALID),
        .DOUT      (DOUT),
        .oLAST     (oLAST),
        .oCH_ID    (oCH_ID),
        .BUSY      (BUSY),
        .LEN_ERR   (LEN_ERR)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- source driver: one frame queue per channel ----------------
    initial begin : driver
        logic [N_CH-1:0] fire;
        forever begin
            @(negedge CLK);
            fire = iVALID & oREADY & {N_CH{RESETN}};
            @(posedge CLK);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (fire[c] && RESETN && src_q[c].size() > 0) begin
                    void'(src_q[c].pop_front());
                    acc_cnt++;
                end
                iVALID[c] = (src_q[c].size() > 0);
                DIN[c*DW +: DW] = (src_q[c].size() > 0) ? src_q[c][0] : '0;
            end
        end
    end

    // ---------------- sink: iREADY always high or 1,0,0 pattern ----------------
    initial begin : sink
        forever begin
            @(posedge CLK);
            #1;
            if (stall_mode) begin
                iREADY = (stall_phase == 0);
                stall_phase = (stall_phase + 1) % 3;
            end else begin
                iREADY = 1'b1;
                stall_phase = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [EW-1:0] got;
        forever begin
            @(negedge CLK);
            if (RESETN) begin
                if (acc_cnt - del_cnt >= 2) begin
                    saw_full = 1'b1;
                    n_cmp++;
                    if (oREADY !== '0) begin
                        n_fail++;
                        $display("FAIL skid_full_ready: oREADY=%b with %0d words buffered, required 0", oREADY, acc_cnt - del_cnt);
                    end
                end
                if (oVALID === 1'b1) begin
                    got = {DOUT, oLAST, oCH_ID};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL out_unexpected: got word %h, required no output", got);
                    end else if (got !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL out_word: got data=%h last=%b ch=%0d, required data=%h last=%b ch=%0d",
                                 got[EW-1:CHW+1], got[CHW], got[CHW-1:0],
                                 exp_q[0][EW-1:CHW+1], exp_q[0][CHW], exp_q[0][CHW-1:0]);
                    end
                    if (iREADY === 1'b1) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        del_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame(input int ch, input int len, input bit to_exp);
        logic [DW-1:0] w;
        for (int i = 0; i < len + 2; i++) begin
            if (i == 0) w = {4'hA, 4'(ch), 16'(frame_no), 32'($urandom), 8'(len)};
            else        w = {4'hD, 4'(ch), 16'(frame_no), 8'(i), 32'($urandom_range(0, 32'hFFFF_FFFF))};
            src_q[ch].push_back(w);
            if (to_exp) exp_q.push_back({w, (i == len + 1), 4'(ch)});
        end
        frame_no++;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic wait_out(input int ch, input bit need_last, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge CLK);
            n++;
            if (oVALID === 1'b1 && oCH_ID === 4'(ch) && (!need_last || oLAST === 1'b1)) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_out_ch%0d: no matching output in %0d cycles, required one", ch, budget);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (oREADY !== '0)   begin n_fail++; $display("FAIL reset_oready: got %b, required 0", oREADY); end
        n_cmp++; if (oVALID !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b, required 0", oVALID); end
        n_cmp++; if (DOUT !== '0)     begin n_fail++; $display("FAIL reset_dout: got %h, required 0", DOUT); end
        n_cmp++; if ({oLAST, oCH_ID} !== '0) begin n_fail++; $display("FAIL reset_tag: got last=%b ch=%0d, required 0/0", oLAST, oCH_ID); end
        n_cmp++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
        n_cmp++; if (LEN_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b, required 0", LEN_ERR); end
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", BUSY); end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N_CH; c++) push_frame(c, 1, 1'b1);
        wait_drain(200, "round_robin");
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rr_busy_end: got %b, required 0", BUSY); end
    endtask

    task automatic test_single_frame();
        bit ok;
        push_frame(0, 3, 1'b1);
        wait_out(0, 1'b0, 20, ok);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            n_cmp++;
            if (oVALID !== 1'b1) begin
                n_fail++;
                $display("FAIL single_contig: word %0d oVALID=%b, required 1", i, oVALID);
            end
        end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_ftr: got %b, required 0", BUSY); end
        wait_drain(20, "single");
    endtask

    task automatic test_zero_len();
        bit ok;
        push_frame(1, 0, 1'b1);
        push_frame(2, 2, 1'b1);
        wait_out(1, 1'b1, 30, ok);
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL zl_idle_busy: got %b, required 0", BUSY); end
        @(negedge CLK);
        n_cmp++; if ({BUSY, oVALID} !== 2'b10) begin n_fail++; $display("FAIL zl_gap: got busy=%b ovalid=%b, required 1/0", BUSY, oVALID); end
        @(negedge CLK);
        n_cmp++; if (oVALID !== 1'b1 || oCH_ID !== 4'd2) begin n_fail++; $display("FAIL zl_next_grant: got ovalid=%b ch=%0d, required 1/2", oVALID, oCH_ID); end
        wait_drain(30, "zero_len");
    endtask

    task automatic test_backpressure();
        saw_full = 1'b0;
        stall_mode = 1'b1;
        push_frame(0, 4, 1'b1);
        wait_drain(100, "backpressure");
        stall_mode = 1'b0;
        n_cmp++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL bp_fill: skid full seen=%b, required 1", saw_full); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_len_err();
        bit ok;
        n_cmp++; if (LEN_ERR !== 1'b0) begin n_fail++; $display("FAIL le_before: got %b, required 0", LEN_ERR); end
        push_frame(3, 201, 1'b1);
        wait_out(3, 1'b0, 30, ok);
        n_cmp++; if (LEN_ERR !== 1'b1) begin n_fail++; $display("FAIL le_after_hdr: got %b, required 1", LEN_ERR); end
        CH_ENABLE[3] = 1'b0;
        wait_drain(400, "len_err_frame");
        n_cmp++; if (LEN_ERR !== 1'b1) begin n_fail++; $display("FAIL le_sticky: got %b, required 1", LEN_ERR); end
        push_frame(3, 2, 1'b0);
        push_frame(0, 1, 1'b1);
        wait_drain(50, "len_err_ch0");
        repeat (10) @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL le_blocked_busy: got %b, required 0", BUSY); end
        n_cmp++; if (src_q[3].size() != 4) begin n_fail++; $display("FAIL le_blocked_src: %0d ch3 words left, required 4", src_q[3].size()); end
        src_q[3].delete();
        repeat (3) @(negedge CLK);
        CH_ENABLE[3] = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        push_frame(2, 20, 1'b1);
        wait_out(2, 1'b0, 30, ok);
        repeat (3) @(negedge CLK);
        #2;
        RESETN = 1'b0;
        #1;
        n_cmp++; if (oVALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovalid: got %b, required 0", oVALID); end
        n_cmp++; if (oREADY !== '0)   begin n_fail++; $display("FAIL rst_mid_oready: got %b, required 0", oREADY); end
        n_cmp++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", BUSY); end
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) src_q[c].delete();
        acc_cnt = 0;
        del_cnt = 0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        push_frame(0, 1, 1'b1);
        push_frame(1, 1, 1'b1);
        wait_drain(40, "after_reset");
    endtask

    // ---------------- sequence and report ----------------
    initial begin : main
        test_reset();
        test_round_robin();
        test_single_frame();
        test_zero_len();
        test_backpressure();
        test_len_err();
        test_reset_mid_frame();
        repeat (5) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
